// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze pipeline: default sample width,
// window indexing helpers and the tracker state type.
package dehaze_pkg;

  localparam int DATA_W_DEF = 8;

  // Frame tracker state: waiting for a start-of-frame, or inside a frame.
  typedef enum logic {
    TRK_IDLE   = 1'b0,
    TRK_ACTIVE = 1'b1
  } trk_state_e;

  // Row-major index of the centre pixel of an odd win x win window.
  function automatic int centre_idx(input int win);
    return (win * win) / 2;
  endfunction

  // LSB position of channel c, pixel p inside a flattened window bus.
  function automatic int pix_lsb(input int c, input int p, input int win, input int data_w);
    return (c * win * win + p) * data_w;
  endfunction

endpackage

// File: rtl/atmo_light_est_if.sv
// Window stream in, atmospheric-light result out. The upstream window
// generator and result consumer use the master side; the estimator is the slave.
interface atmo_light_est_if #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int WIN    = 3
) ();

  logic [NCH*WIN*WIN*DATA_W-1:0] win_i;
  logic                          valid_i;
  logic                          sof_i;
  logic                          eof_i;
  logic                          smooth_en_i;
  logic [NCH*DATA_W-1:0]         a_o;
  logic [DATA_W-1:0]             dark_max_o;
  logic                          a_valid_o;

  modport master (
    output win_i, valid_i, sof_i, eof_i, smooth_en_i,
    input  a_o, dark_max_o, a_valid_o
  );

  modport slave (
    input  win_i, valid_i, sof_i, eof_i, smooth_en_i,
    output a_o, dark_max_o, a_valid_o
  );

endinterface

// File: rtl/atmo_light_est_min.sv
// Combinational minimum of N packed DATA_W-bit samples. Used per channel
// over a window and again across channels for the dark-channel value.
module chan_win_min #(
  parameter int DATA_W = 8,
  parameter int N      = 9
) (
  input  logic [N*DATA_W-1:0] data,
  output logic [DATA_W-1:0]   min_val
);

  // Linear scan; synthesis rebalances the compare chain as needed.
  // NOTE: min_val gets a value before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    min_val = data[DATA_W-1:0];
    for (int i = 1; i < N; i++) begin
      if (data[i*DATA_W +: DATA_W] < min_val) begin
        min_val = data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/atmo_light_est.sv
// Atmospheric-light estimator: per-window dark channel, per-frame maximum
// tracking, and optional temporal IIR smoothing of the resulting colour.
module atmo_light_est
  import dehaze_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NCH       = 3,
  parameter int WIN       = 3,
  parameter int SMOOTH_SH = 2
) (
  input logic             clk,
  input logic             reset,
  atmo_light_est_if.slave bus
);

  localparam int NPIX = WIN * WIN;
  localparam int CTR  = centre_idx(WIN);
  localparam int PW   = NCH * DATA_W;

  logic [PW-1:0]     ch_min, win_ctr;
  logic [PW-1:0]     s1_min, s1_ctr;
  logic              s1_valid, s1_sof, s1_eof;
  logic [DATA_W-1:0] dark_comb, s2_dark;
  logic [PW-1:0]     s2_ctr;
  logic              s2_valid, s2_sof, s2_eof;
  trk_state_e        state, state_nxt;
  logic              best_upd, close_frame, close_q;
  logic [DATA_W-1:0] best_dark, dark_frame, dark_q;
  logic [PW-1:0]     best_rgb, a_frame, a_q, a_smooth;
  logic              done, a_valid_q, have_prev;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    chan_win_min #(.DATA_W(DATA_W), .N(NPIX)) u_win_min (
      .data    (bus.win_i[pix_lsb(c, 0, WIN, DATA_W) +: NPIX*DATA_W]),
      .min_val (ch_min[c*DATA_W +: DATA_W])
    );
    assign win_ctr[c*DATA_W +: DATA_W] = bus.win_i[pix_lsb(c, CTR, WIN, DATA_W) +: DATA_W];
  end

  // S1 control: delay the window qualifiers by one stage.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= bus.valid_i;
      s1_sof   <= bus.valid_i & bus.sof_i;
      s1_eof   <= bus.valid_i & bus.eof_i;
    end
  end

  // S1 data: per-channel window minima and centre colour.
  // NOTE: datapath registers are not reset; they are only read when their valid is set.
  always_ff @(posedge clk) begin
    if (bus.valid_i) begin
      s1_min <= ch_min;
      s1_ctr <= win_ctr;
    end
  end

  chan_win_min #(.DATA_W(DATA_W), .N(NCH)) u_dark_min (
    .data    (s1_min),
    .min_val (dark_comb)
  );

  // S2 control: delay the qualifiers once more.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eof   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eof   <= s1_eof;
    end
  end

  // S2 data: dark-channel value and centre colour.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_dark <= dark_comb;
      s2_ctr  <= s1_ctr;
    end
  end

  // S3 tracker next-state: restart on sof, strict-greater update, close on eof.
  always_comb begin
    state_nxt   = state;
    best_upd    = 1'b0;
    close_frame = 1'b0;
    if (s2_valid) begin
      if (s2_sof) begin
        best_upd  = 1'b1;
        state_nxt = TRK_ACTIVE;
      end else if (state == TRK_ACTIVE && s2_dark > best_dark) begin
        best_upd = 1'b1;
      end
      if (s2_eof && (s2_sof || state == TRK_ACTIVE)) begin
        close_frame = 1'b1;
        state_nxt   = TRK_IDLE;
      end
    end
  end

  // S3 tracker registers: frame state and running best window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TRK_IDLE;
      best_dark <= '0;
      best_rgb  <= '0;
      close_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      close_q <= close_frame;
      if (best_upd) begin
        best_dark <= s2_dark;
        best_rgb  <= s2_ctr;
      end
    end
  end

  // Frame result handoff pulse, one cycle after the frame closes.
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= close_q;
  end

  // Snapshot of the closed frame's best window, decoupled from the tracker.
  always_ff @(posedge clk) begin
    if (close_q) begin
      a_frame    <= best_rgb;
      dark_frame <= best_dark;
    end
  end

  // IIR step per channel: a + floor((new - a) / 2^SMOOTH_SH), stays in range.
  for (genvar c = 0; c < NCH; c++) begin : g_smooth
    logic signed [DATA_W:0] diff, step;
    assign diff = $signed({1'b0, a_frame[c*DATA_W +: DATA_W]}) - $signed({1'b0, a_q[c*DATA_W +: DATA_W]});
    assign step = diff >>> SMOOTH_SH;
    assign a_smooth[c*DATA_W +: DATA_W] = DATA_W'(a_q[c*DATA_W +: DATA_W] + step);
  end

  // S4 output: publish the frame result, smoothed when a previous A exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      dark_q    <= '0;
      a_valid_q <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      a_valid_q <= done;
      if (done) begin
        a_q       <= (bus.smooth_en_i && have_prev) ? a_smooth : a_frame;
        dark_q    <= dark_frame;
        have_prev <= 1'b1;
      end
    end
  end

  assign bus.a_o        = a_q;
  assign bus.dark_max_o = dark_q;
  assign bus.a_valid_o  = a_valid_q;

endmodule

// File: tb/tb_atmo_light_est.sv
// Scoreboard bench for atmo_light_est: a frame model predicts each result
// when the eof window is driven; monitors compare on every a_valid_o pulse.
module tb_atmo_light_est;

  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int WIN = 3;
  localparam int SH  = 2;
  localparam int WB  = NCH * WIN * WIN * DW;
  localparam int PW  = NCH * DW;
  localparam int WIN5 = 5;
  localparam int WB5  = WIN5 * WIN5 * DW;

  typedef struct {
    logic [PW-1:0] a;
    logic [DW-1:0] dark;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] dark;
  } exp5_t;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int pulses5  = 0;

  exp_t  q[$];
  exp5_t q5[$];
  exp_t  mon_e;
  exp5_t mon_e5;

  // Reference model state
  bit            m_active;
  int            m_best_dark;
  logic [PW-1:0] m_best_rgb;
  logic [PW-1:0] m_prev_a;
  bit            m_have_prev;

  atmo_light_est_if #(.DATA_W(DW), .NCH(NCH), .WIN(WIN)) bus ();
  atmo_light_est_if #(.DATA_W(DW), .NCH(1), .WIN(WIN5)) bus5 ();

  atmo_light_est #(.DATA_W(DW), .NCH(NCH), .WIN(WIN), .SMOOTH_SH(SH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  atmo_light_est #(.DATA_W(DW), .NCH(1), .WIN(WIN5), .SMOOTH_SH(SH)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Main DUT monitor
  always @(negedge clk) begin
    if (bus.a_valid_o === 1'b1) begin
      pulses++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse a_o=%h dark_max_o=%0d (no result expected)", bus.a_o, bus.dark_max_o);
      end else begin
        mon_e = q.pop_front();
        if (bus.a_o !== mon_e.a) begin
          failures++;
          $display("FAIL a_o got=%h exp=%h", bus.a_o, mon_e.a);
        end
        checks++;
        if (bus.dark_max_o !== mon_e.dark) begin
          failures++;
          $display("FAIL dark_max_o got=%0d exp=%0d", bus.dark_max_o, mon_e.dark);
        end
      end
    end
  end

  // NCH=1, WIN=5 DUT monitor
  always @(negedge clk) begin
    if (bus5.a_valid_o === 1'b1) begin
      pulses5++;
      checks++;
      if (q5.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse5 a_o=%h", bus5.a_o);
      end else begin
        mon_e5 = q5.pop_front();
        if (bus5.a_o !== mon_e5.a || bus5.dark_max_o !== mon_e5.dark) begin
          failures++;
          $display("FAIL nch1 got a=%0d dark=%0d exp a=%0d dark=%0d",
                   bus5.a_o, bus5.dark_max_o, mon_e5.a, mon_e5.dark);
        end
      end
    end
  end

  // Window with given centre colour whose global minimum is exactly dark.
  function automatic logic [WB-1:0] make_win(input int dark, input int r0, input int r1, input int r2);
    logic [WB-1:0] w;
    int rgb[3];
    int ctr, pc, pp;
    rgb[0] = r0; rgb[1] = r1; rgb[2] = r2;
    ctr = (WIN * WIN) / 2;
    for (int c = 0; c < NCH; c++) begin
      for (int p = 0; p < WIN * WIN; p++) begin
        if (p == ctr) w[(c*WIN*WIN+p)*DW +: DW] = DW'(rgb[c]);
        else          w[(c*WIN*WIN+p)*DW +: DW] = DW'($urandom_range(255, dark));
      end
    end
    pc = int'($urandom_range(NCH - 1, 0));
    pp = int'($urandom_range(WIN * WIN - 2, 0));
    if (pp >= ctr) pp++;
    w[(pc*WIN*WIN+pp)*DW +: DW] = DW'(dark);
    return w;
  endfunction

  function automatic int win_dark(input logic [WB-1:0] w);
    int m = 255;
    for (int i = 0; i < NCH * WIN * WIN; i++) begin
      if (int'(w[i*DW +: DW]) < m) m = int'(w[i*DW +: DW]);
    end
    return m;
  endfunction

  function automatic logic [PW-1:0] win_ctr(input logic [WB-1:0] w);
    logic [PW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = w[(c*WIN*WIN + (WIN*WIN)/2)*DW +: DW];
    return r;
  endfunction

  task automatic model_push();
    exp_t e;
    int o, n, r;
    for (int c = 0; c < NCH; c++) begin
      o = int'(m_prev_a[c*DW +: DW]);
      n = int'(m_best_rgb[c*DW +: DW]);
      if (bus.smooth_en_i && m_have_prev) r = o + ((n - o) >>> SH);
      else                                r = n;
      e.a[c*DW +: DW] = DW'(r);
    end
    e.dark = DW'(m_best_dark);
    q.push_back(e);
    m_prev_a    = e.a;
    m_have_prev = 1'b1;
  endtask

  task automatic model_accept(input logic [WB-1:0] w, input bit sof, input bit eof);
    int d;
    d = win_dark(w);
    if (sof) begin
      m_active    = 1'b1;
      m_best_dark = d;
      m_best_rgb  = win_ctr(w);
    end else if (m_active && d > m_best_dark) begin
      m_best_dark = d;
      m_best_rgb  = win_ctr(w);
    end
    if (eof && m_active) begin
      model_push();
      m_active = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_best_dark = 0;
    m_best_rgb  = '0;
    m_prev_a    = '0;
    m_have_prev = 1'b0;
  endtask

  task automatic drive_win(input logic [WB-1:0] w, input bit sof, input bit eof);
    @(negedge clk);
    bus.win_i   = w;
    bus.valid_i = 1'b1;
    bus.sof_i   = sof;
    bus.eof_i   = eof;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    bus.eof_i   = 1'b0;
    model_accept(w, sof, eof);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s drain_timeout pending=%0d required=0", name, q.size());
      q.delete();
    end
    idle(6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_out(input string name, input logic [PW-1:0] a, input logic [DW-1:0] d);
    checks++;
    if (bus.a_o !== a || bus.dark_max_o !== d) begin
      failures++;
      $display("FAIL %s got a=%h dark=%0d exp a=%h dark=%0d", name, bus.a_o, bus.dark_max_o, a, d);
    end
  endtask

  task automatic check_pulses(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s pulses got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    idle(2);
    checks++;
    if (bus.a_o !== '0 || bus.dark_max_o !== '0 || bus.a_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got a=%h dark=%0d v=%b exp all 0", bus.a_o, bus.dark_max_o, bus.a_valid_o);
    end
  endtask

  task automatic test_basic();
    int lat = 0, high = 0;
    bus.smooth_en_i = 1'b0;
    drive_win(make_win(10, 90, 80, 70), 1, 0);
    drive_win(make_win(50, 200, 190, 180), 0, 0);
    drive_win(make_win(50, 60, 70, 80), 0, 0);
    drive_win(make_win(30, 35, 40, 45), 0, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.a_valid_o === 1'b1) begin
        high++;
        if (lat == 0) lat = i;
      end
    end
    checks++;
    if (lat - 1 !== 4) begin
      failures++;
      $display("FAIL latency edges got=%0d exp=4", lat - 1);
    end
    checks++;
    if (high !== 1) begin
      failures++;
      $display("FAIL pulse_width got=%0d exp=1", high);
    end
    drain("basic");
    check_out("basic_value", {8'd180, 8'd190, 8'd200}, 8'd50);
  endtask

  task automatic smooth_frame(input int a_val);
    drive_win(make_win(5, a_val, a_val, a_val), 1, 0);
    drive_win(make_win(3, 20, 20, 20), 0, 1);
    drain("smooth");
  endtask

  task automatic test_smoothing();
    bus.smooth_en_i = 1'b0;
    smooth_frame(100);
    check_out("smooth_f1", {3{8'd100}}, 8'd5);
    bus.smooth_en_i = 1'b1;
    smooth_frame(200);
    check_out("smooth_f2", {3{8'd125}}, 8'd5);
    smooth_frame(100);
    check_out("smooth_f3", {3{8'd118}}, 8'd5);
    bus.smooth_en_i = 1'b0;
    smooth_frame(100);
    check_out("smooth_off", {3{8'd100}}, 8'd5);
  endtask

  task automatic test_restart();
    int p0 = pulses;
    bus.smooth_en_i = 1'b0;
    drive_win(make_win(250, 250, 251, 252), 1, 0);
    drive_win(make_win(20, 30, 31, 32), 1, 0);
    drive_win(make_win(40, 60, 61, 62), 0, 1);
    drain("restart");
    check_pulses("restart", pulses - p0, 1);
    check_out("restart_value", {8'd62, 8'd61, 8'd60}, 8'd40);
  endtask

  task automatic test_reset_mid_frame();
    int p0 = pulses;
    bus.smooth_en_i = 1'b1;
    drive_win(make_win(60, 70, 70, 70), 1, 0);
    drive_win(make_win(80, 90, 90, 90), 0, 0);
    do_reset();
    idle(8);
    check_pulses("reset_mid", pulses - p0, 0);
    check_out("reset_mid_out", '0, '0);
    drive_win(make_win(15, 40, 50, 60), 1, 0);
    drive_win(make_win(12, 33, 44, 55), 0, 1);
    drain("reset_next");
    check_out("reset_next_raw", {8'd60, 8'd50, 8'd40}, 8'd15);
  endtask

  task automatic test_single_and_gaps();
    int p0 = pulses;
    bus.smooth_en_i = 1'b0;
    drive_win(make_win(0, 5, 5, 5), 0, 0);
    drive_win(make_win(33, 50, 60, 70), 1, 1);
    idle(3);
    drive_win(make_win(10, 20, 20, 20), 1, 0);
    idle(2);
    drive_win(make_win(90, 100, 110, 120), 0, 0);
    idle(3);
    drive_win(make_win(40, 45, 45, 45), 0, 1);
    drive_win(make_win(200, 210, 210, 210), 0, 1);
    drain("gaps");
    check_pulses("single_gaps", pulses - p0, 2);
    check_out("gaps_value", {8'd120, 8'd110, 8'd100}, 8'd90);
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    bus.smooth_en_i = 1'b0;
    drive_win(make_win(7, 11, 12, 13), 1, 1);
    drive_win(make_win(8, 14, 15, 16), 1, 1);
    drive_win(make_win(9, 17, 18, 19), 1, 0);
    drive_win(make_win(3, 20, 21, 22), 0, 1);
    drain("b2b");
    check_pulses("back_to_back", pulses - p0, 3);
    check_out("b2b_value", {8'd19, 8'd18, 8'd17}, 8'd9);
  endtask

  task automatic test_extremes();
    bus.smooth_en_i = 1'b0;
    drive_win(make_win(0, 9, 8, 7), 1, 0);
    drive_win(make_win(0, 100, 100, 100), 0, 0);
    drive_win('0, 0, 1);
    drain("zero");
    check_out("all_zero", {8'd7, 8'd8, 8'd9}, 8'd0);
    drive_win('1, 1, 0);
    drive_win('1, 0, 1);
    drain("ones");
    check_out("all_ones", {3{8'd255}}, 8'd255);
  endtask

  function automatic logic [WB5-1:0] make_win5(input int dark, input int ctr_val);
    logic [WB5-1:0] w;
    for (int p = 0; p < WIN5 * WIN5; p++) w[p*DW +: DW] = DW'($urandom_range(255, dark));
    w[((WIN5*WIN5)/2)*DW +: DW] = DW'(ctr_val);
    w[DW-1:0] = DW'(dark);
    return w;
  endfunction

  task automatic drive5(input logic [WB5-1:0] w, input bit sof, input bit eof);
    @(negedge clk);
    bus5.win_i   = w;
    bus5.valid_i = 1'b1;
    bus5.sof_i   = sof;
    bus5.eof_i   = eof;
    @(posedge clk);
    #1;
    bus5.valid_i = 1'b0;
    bus5.sof_i   = 1'b0;
    bus5.eof_i   = 1'b0;
  endtask

  task automatic test_nch1();
    exp5_t e;
    int p0 = pulses5;
    int n = 0;
    e.a = 8'd200;
    e.dark = 8'd50;
    q5.push_back(e);
    drive5(make_win5(10, 90), 1, 0);
    drive5(make_win5(50, 200), 0, 0);
    drive5(make_win5(50, 60), 0, 0);
    drive5(make_win5(30, 35), 0, 1);
    while (q5.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    idle(4);
    check_pulses("nch1", pulses5 - p0, 1);
  endtask

  initial begin
    reset            = 1'b1;
    bus.win_i        = '0;
    bus.valid_i      = 1'b0;
    bus.sof_i        = 1'b0;
    bus.eof_i        = 1'b0;
    bus.smooth_en_i  = 1'b0;
    bus5.win_i       = '0;
    bus5.valid_i     = 1'b0;
    bus5.sof_i       = 1'b0;
    bus5.eof_i       = 1'b0;
    bus5.smooth_en_i = 1'b0;
    model_reset();

    test_reset();
    test_basic();
    test_smoothing();
    test_restart();
    test_reset_mid_frame();
    test_single_and_gaps();
    test_back_to_back();
    test_extremes();
    test_nch1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
